// File: rtl/ifft8_pkg.sv
// rtl/ifft8_pkg.sv - shared types, twiddle table and helpers for the 8-point inverse FFT
//
// Contents:
//   state_t        sequencer states LOAD / COMPUTE / OUTPUT
//   TWID           width of the twiddle table entries (Q1.6, 1.0 = 64)
//   tw_re / tw_im  conjugated (inverse-transform) twiddles W^-t, t = 0..3
//   bitrev3        3-bit bit reversal used for the in-place DIT input order
//   RND / SHIFT    rounding constant and shift applied after each twiddle multiply

package ifft8_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    localparam int TWID  = 8;
    localparam int RND   = 32;
    localparam int SHIFT = 6;

    // exp(+j*2*pi*t/8) in Q1.6: the inverse transform rotates the other way
    function automatic logic signed [TWID-1:0] tw_re(input logic [1:0] t);
        case (t)
            2'd0:    tw_re = 8'sd64;
            2'd1:    tw_re = 8'sd45;
            2'd2:    tw_re = 8'sd0;
            default: tw_re = -8'sd45;
        endcase
    endfunction

    function automatic logic signed [TWID-1:0] tw_im(input logic [1:0] t);
        case (t)
            2'd0:    tw_im = 8'sd0;
            2'd1:    tw_im = 8'sd45;
            2'd2:    tw_im = 8'sd64;
            default: tw_im = 8'sd45;
        endcase
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        bitrev3 = {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// rtl/ifft8_bfly.sv - combinational radix-2 DIT butterfly with rounded twiddle multiply
//
// Computes P = round(W*B / 64), then top = A + P, bot = A - P.
// Ports:
//   a_re, a_im      in   IW  upper butterfly input A
//   b_re, b_im      in   IW  lower butterfly input B
//   w_re, w_im      in   TW  twiddle W in Q1.6
//   top_re, top_im  out  IW  A + P
//   bot_re, bot_im  out  IW  A - P

module ifft8_bfly
    import ifft8_pkg::*;
#(
    parameter int IW = 12,
    parameter int TW = 8
) (
    input  logic signed [IW-1:0] a_re,
    input  logic signed [IW-1:0] a_im,
    input  logic signed [IW-1:0] b_re,
    input  logic signed [IW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [IW-1:0] top_re,
    output logic signed [IW-1:0] top_im,
    output logic signed [IW-1:0] bot_re,
    output logic signed [IW-1:0] bot_im
);

    localparam int MW = IW + TW;
    localparam int PW = MW + 1;

    logic signed [MW-1:0] m_rr;
    logic signed [MW-1:0] m_ii;
    logic signed [MW-1:0] m_ri;
    logic signed [MW-1:0] m_ir;
    logic signed [PW-1:0] s_re;
    logic signed [PW-1:0] s_im;
    logic signed [IW-1:0] p_re;
    logic signed [IW-1:0] p_im;

    always_comb begin
        m_rr = MW'(b_re) * MW'(w_re);
        m_ii = MW'(b_im) * MW'(w_im);
        m_ri = MW'(b_im) * MW'(w_re);
        m_ir = MW'(b_re) * MW'(w_im);

        // Round half up, then arithmetic shift back to the working scale
        s_re = PW'(m_rr) - PW'(m_ii) + PW'(RND);
        s_im = PW'(m_ri) + PW'(m_ir) + PW'(RND);
        p_re = IW'(s_re >>> SHIFT);
        p_im = IW'(s_im >>> SHIFT);

        top_re = a_re + p_re;
        top_im = a_im + p_im;
        bot_re = a_re - p_re;
        bot_im = a_im - p_im;
    end

endmodule

// File: rtl/ifft8_seq.sv
// rtl/ifft8_seq.sv - sequential 8-point radix-2 DIT inverse FFT, one butterfly per cycle
//
// Loads X[0..7] in natural order into a bit-reversed working buffer, runs
// 3 stages x 4 butterflies in place, then streams x[0..7] scaled by 1/8.
// Option macro IFFT8_SAT_EN: clamp the scaled output to the DW range
// instead of wrapping to the low DW bits.
// Ports:
//   clk                 in   1   rising-edge clock
//   rst                 in   1   asynchronous active-high reset
//   in_valid, in_ready  in/out   input handshake (in_ready only in LOAD)
//   in_re, in_im        in   DW  spectrum sample X[k]
//   out_valid,out_ready out/in   output handshake
//   out_re, out_im      out  DW  time sample x[n]
//   out_last            out  1   marks n = 7
//   busy                out  1   high while computing or streaming out

module ifft8_seq
    import ifft8_pkg::*;
#(
    parameter int DW = 8,
    parameter int IW = DW + 4,
    parameter int TW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 busy
);

    state_t     state;
    logic [2:0] k;
    logic [1:0] s;
    logic [1:0] b;
    logic [2:0] n;

    logic signed [IW-1:0] mem_re [8];
    logic signed [IW-1:0] mem_im [8];

    logic [2:0] top_a;
    logic [2:0] bot_a;
    logic [1:0] tw_i;

    logic signed [IW-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [IW-1:0] top_re, top_im, bot_re, bot_im;

    logic [2:0]           rd_addr;
    logic signed [IW-1:0] rd_re;
    logic signed [IW-1:0] rd_im;

    // Butterfly addressing: span h = 1<<s, top = (b>>s)*2h + (b & (h-1)),
    // bot = top + h, twiddle index = (b & (h-1)) << (2-s).
    always_comb begin
        top_a = 3'd0;
        bot_a = 3'd0;
        tw_i  = 2'd0;
        case (s)
            2'd0: begin
                top_a = {b, 1'b0};
                bot_a = {b, 1'b1};
                tw_i  = 2'd0;
            end
            2'd1: begin
                top_a = {b[1], 1'b0, b[0]};
                bot_a = {b[1], 1'b1, b[0]};
                tw_i  = {b[0], 1'b0};
            end
            2'd2: begin
                top_a = {1'b0, b};
                bot_a = {1'b1, b};
                tw_i  = b;
            end
            default: begin
                top_a = 3'd0;
                bot_a = 3'd0;
                tw_i  = 2'd0;
            end
        endcase
    end

    assign a_re = mem_re[top_a];
    assign a_im = mem_im[top_a];
    assign b_re = mem_re[bot_a];
    assign b_im = mem_im[bot_a];
    assign w_re = TW'(tw_re(tw_i));
    assign w_im = TW'(tw_im(tw_i));

    ifft8_bfly #(
        .IW (IW),
        .TW (TW)
    ) u_bfly (
        .a_re   (a_re),
        .a_im   (a_im),
        .b_re   (b_re),
        .b_im   (b_im),
        .w_re   (w_re),
        .w_im   (w_im),
        .top_re (top_re),
        .top_im (top_im),
        .bot_re (bot_re),
        .bot_im (bot_im)
    );

    // While the output register is empty it is loaded from n; once it holds
    // sample n, the next handshake loads n+1, so there are no bubbles.
    assign rd_addr = n + {2'b00, out_valid};
    assign rd_re   = mem_re[rd_addr];
    assign rd_im   = mem_im[rd_addr];

    function automatic logic signed [DW-1:0] scale_out(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] q;
        q = v >>> 3;
`ifdef IFFT8_SAT_EN
        if (q > IW'((2 ** (DW - 1)) - 1))
            scale_out = {1'b0, {(DW-1){1'b1}}};
        else if (q < IW'(-(2 ** (DW - 1))))
            scale_out = {1'b1, {(DW-1){1'b0}}};
        else
            scale_out = DW'(q);
`else
        scale_out = DW'(q);
`endif
    endfunction

    // Working buffer: no reset, every frame rewrites all 8 entries in LOAD
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready) begin
            mem_re[bitrev3(k)] <= IW'(in_re);
            mem_im[bitrev3(k)] <= IW'(in_im);
        end else if (state == COMPUTE) begin
            mem_re[top_a] <= top_re;
            mem_im[top_a] <= top_im;
            mem_re[bot_a] <= bot_re;
            mem_im[bot_a] <= bot_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            k         <= 3'd0;
            s         <= 2'd0;
            b         <= 2'd0;
            n         <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        k <= k + 3'd1;
                        if (k == 3'd7) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end

                COMPUTE: begin
                    b <= b + 2'd1;
                    if (b == 2'd3) begin
                        if (s == 2'd2) begin
                            s     <= 2'd0;
                            state <= OUTPUT;
                        end else begin
                            s <= s + 2'd1;
                        end
                    end
                end

                OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_re    <= scale_out(rd_re);
                        out_im    <= scale_out(rd_im);
                        out_last  <= (n == 3'd7);
                    end else if (out_ready) begin
                        if (n == 3'd7) begin
                            state     <= LOAD;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            n         <= 3'd0;
                        end else begin
                            n        <= n + 3'd1;
                            out_re   <= scale_out(rd_re);
                            out_im   <= scale_out(rd_im);
                            out_last <= (n == 3'd6);
                        end
                    end
                end

                default: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
